// File: rtl/fetch_unit_if.sv
// fetch_unit_if: control, PC and memory handshake bundle between the LC-3 fetch sequencer and its environment.
interface fetch_unit_if;
    logic        start;
    logic [15:0] PCIn;
    logic [15:0] memData;
    logic        memReady;
    logic [15:0] memAddr;
    logic        memRead;
    logic        ldPC;
    logic [1:0]  selPC;
    logic [15:0] marOut;
    logic [15:0] mdrOut;
    logic [15:0] IROut;
    logic        busy;
    logic        fetchDone;
    logic        fetchErr;

    modport master (
        input  start, PCIn, memData, memReady,
        output memAddr, memRead, ldPC, selPC, marOut, mdrOut, IROut, busy, fetchDone, fetchErr
    );

    modport slave (
        output start, PCIn, memData, memReady,
        input  memAddr, memRead, ldPC, selPC, marOut, mdrOut, IROut, busy, fetchDone, fetchErr
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: LC-3 instruction-fetch sequencer (FSM states 18, 33, 35) sitting after the PC register.
// Optional macro FETCH_TIMEOUT_EN adds a memory-wait timeout that aborts the fetch with a fetchErr pulse.
module fetch_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic         clk,
    input logic         reset,
    fetch_unit_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INC  = 3'd1,
        S_WAIT = 3'd2,
        S_LDIR = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      r_state;
    logic [15:0] r_mar;
    logic [15:0] r_mdr;
    logic [15:0] r_ir;
    logic        r_ldPC;
    logic        r_memRead;
    logic        r_busy;
    logic        r_fetchDone;
    logic        r_fetchErr;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] r_wait_cnt;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^8'(TIMEOUT_CYCLES);
`endif

    // Sequencer: outputs are registered so each one is set on the edge entering the state that owns it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_mar       <= 16'h0000;
            r_mdr       <= 16'h0000;
            r_ir        <= 16'h0000;
            r_ldPC      <= 1'b0;
            r_memRead   <= 1'b0;
            r_busy      <= 1'b0;
            r_fetchDone <= 1'b0;
            r_fetchErr  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            r_wait_cnt  <= 8'd0;
`endif
        end else begin
            r_ldPC      <= 1'b0;
            r_memRead   <= 1'b0;
            r_fetchDone <= 1'b0;
            r_fetchErr  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_mar   <= bus.PCIn;
                        r_state <= S_INC;
                        r_ldPC  <= 1'b1;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_INC: begin
                    r_state   <= S_WAIT;
                    r_memRead <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    r_wait_cnt <= 8'd0;
`endif
                end
                S_WAIT: begin
                    if (bus.memReady) begin
                        r_mdr   <= bus.memData;
                        r_state <= S_LDIR;
                    end else begin
`ifdef FETCH_TIMEOUT_EN
                        // Ready arriving on the final cycle takes the branch above, so it always beats the timeout.
                        if (r_wait_cnt == TO_LAST) begin
                            r_state    <= S_IDLE;
                            r_busy     <= 1'b0;
                            r_fetchErr <= 1'b1;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 8'd1;
                            r_memRead  <= 1'b1;
                        end
`else
                        r_memRead <= 1'b1;
`endif
                    end
                end
                S_LDIR: begin
                    r_ir        <= r_mdr;
                    r_state     <= S_DONE;
                    r_fetchDone <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.memAddr   = r_mar;
    assign bus.marOut    = r_mar;
    assign bus.mdrOut    = r_mdr;
    assign bus.IROut     = r_ir;
    assign bus.memRead   = r_memRead;
    assign bus.ldPC      = r_ldPC;
    assign bus.selPC     = 2'b00;
    assign bus.busy      = r_busy;
    assign bus.fetchDone = r_fetchDone;
    assign bus.fetchErr  = r_fetchErr;

endmodule
